id_ex_pipe_stage: RTL
=====================

Name: id_ex_pipe_stage

Overview:
Parametrised ID/EX pipeline stage for the MIPS pipeline. It carries PCs, register-file operands, the sign-extended immediate and the instruction from decode to execute. It adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from EX stalls ID without a combinational ready path. It also adds a flush (bubble) input and a saturating stall-cycle counter. The rs/rt/rd fields are extracted with correct MIPS bit positions.

Parameters:
DATA_W, 32, width of PC, operand and immediate paths
REG_AW, 5, register address width; must be 5 for MIPS field extraction
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all held and incoming beats this cycle
in_valid  input  1  ID presents a beat
in_ready  output  1  stage can accept a beat; registered
cur_pc_in  input  DATA_W  PC of instruction
next_pc_in  input  DATA_W  PC+4
rd1_in  input  DATA_W  register read data 1
rd2_in  input  DATA_W  register read data 2
imm_in  input  DATA_W  sign-extended immediate
instr_in  input  32  instruction word
out_valid  output  1  EX beat valid
out_ready  input  1  EX consumes beat
cur_pc_out, next_pc_out, rd1_out, rd2_out, imm_out  output  DATA_W  registered copies
instr_out  output  32  registered instruction
rs_out  output  REG_AW  instr_out[25:21]
rt_out  output  REG_AW  instr_out[20:16]
rd_out  output  REG_AW  instr_out[15:11]
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main register (drives outputs) and skid register, each with a valid bit. State is encoded by {skid_v, main_v}: EMPTY (0,0), ONE (0,1), TWO (1,1). (1,0) is illegal.
- Reset (rst=1 at a clock edge): main_v=0, skid_v=0, in_ready=1, stall_cnt=0. All data/field outputs go to 0. rst overrides flush and handshakes.
- in_ready = !skid_v, registered. Accept = in_valid & in_ready. Consume = out_valid & out_ready. out_valid = main_v.
- Transitions (flush=0):
  - EMPTY + accept -> ONE, main loads input.
  - ONE + accept + consume -> ONE, main loads input.
  - ONE + accept, no consume -> TWO, skid loads input.
  - ONE + consume, no accept -> EMPTY.
  - TWO + consume -> ONE, main loads skid. No accept is possible in TWO.
  - Otherwise hold.
- Latency: an accepted beat appears on outputs the next cycle when the stage is EMPTY or consumed-through. Throughput is 1 beat/cycle while out_ready=1.
- Ordering: beats leave in acceptance order. No duplication, no loss except by flush.
- Flush=1: main_v and skid_v are 0 next cycle, and in_ready=1 next cycle. An incoming beat in the same cycle is dropped. A consume in the same cycle still counts as delivered to EX. Data registers keep their old values; only the valid bits clear.
- Field outputs are combinational slices of instr_out (rt uses [20:16]) and change only when main loads.
- Data registers load only on the listed transitions. They never change while their valid bit is held.
- stall_cnt: increments by 1 each cycle with main_v=1 and out_ready=0 and flush=0. It saturates at 2^CNT_W-1, with no wrap. It is cleared only by rst.
- Simultaneous rst and flush: reset behaviour applies.

Test Plan:
- Reset then stream: rst 2 cycles, then 4 beats instr=0x012A4020 (add $8,$9,$10) with out_ready=1. Each beat appears 1 cycle later with out_valid=1. rs_out=9, rt_out=10, rd_out=8. in_ready stays 1. stall_cnt=0.
- Back-pressure: out_ready=0 for 3 cycles during a stream with beats A,B,C offered. A is held on outputs. B goes to skid. in_ready falls to 0 one cycle after B is accepted, so C is not accepted. After out_ready=1, order A,B,C is delivered. stall_cnt=3.
- Flush in TWO: fill main and skid, then assert flush with in_valid=1 and beat D. Next cycle out_valid=0 and in_ready=1. D is never output.
- Reset mid-operation: state TWO with stall_cnt=5, then rst=1 with in_valid=1. Next cycle out_valid=0, in_ready=1, stall_cnt=0, all outputs 0.
- Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles. stall_cnt reaches 7 and holds at 7.
- Parameter sweep: DATA_W=16, pass cur_pc_in=0xBEEF through. Output equals 0xBEEF. rs/rt/rd extraction is unchanged.

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - ID/EX pipeline register with 2-entry skid buffer, flush and stall counter
// Outputs come straight from the main register; in_ready comes only from the skid valid flop.
module id_ex_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] cur_pc_in,
    input  logic [DATA_W-1:0] next_pc_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [31:0]       instr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] cur_pc_out,
    output logic [DATA_W-1:0] next_pc_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [31:0]       instr_out,
    output logic [REG_AW-1:0] rs_out,
    output logic [REG_AW-1:0] rt_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BEAT_W = 5 * DATA_W + 32;

    // Encoding is {skid_v, main_v}; 2'b10 never occurs.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   main_q, main_d;
    logic [BEAT_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_in;
    logic                accept, consume;
    logic                load_main_in, load_main_skid, load_skid;

    assign beat_in   = {cur_pc_in, next_pc_in, rd1_in, rd2_in, imm_in, instr_in};
    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d      = S_ONE;
                    load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = S_TWO;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (consume) begin
                    state_d        = S_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush drops everything held or arriving; data registers keep stale contents.
        if (flush) begin
            state_d        = S_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        cnt_d  = cnt_q;
        if (load_main_in) begin
            main_d = beat_in;
        end else if (load_main_skid) begin
            main_d = skid_q;
        end
        if (load_skid) begin
            skid_d = beat_in;
        end
        if (out_valid && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_out   = main_q[31:0];
    assign imm_out     = main_q[32 +: DATA_W];
    assign rd2_out     = main_q[32 + DATA_W +: DATA_W];
    assign rd1_out     = main_q[32 + 2*DATA_W +: DATA_W];
    assign next_pc_out = main_q[32 + 3*DATA_W +: DATA_W];
    assign cur_pc_out  = main_q[32 + 4*DATA_W +: DATA_W];
    assign rs_out      = instr_out[21 +: REG_AW];
    assign rt_out      = instr_out[16 +: REG_AW];
    assign rd_out      = instr_out[11 +: REG_AW];
    assign stall_cnt   = cnt_q;

endmodule
